intdiv_adj_seq: RTL and testbench

Parametrised, multi-cycle final-correction stage for the SD2 non-restoring integer divider.
- Takes the raw quotient (two's complement) and the redundant SD2 remainder from the iteration array.
- Converts the remainder to two's complement D digits per cycle, LSB first, with a borrow chain, and tracks zero-detection.
- Applies the quotient/remainder correction for a selectable rounding mode.
- Replaces the combinational padj/seladj adjust logic; the divider datapath sits before it and the result register after it.

---
 rtl/intdiv_adj_seq.sv | 182 ++++++++++++++++++
 tb/tb_intdiv_adj_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_adj_seq.sv
// rtl/intdiv_adj_seq.sv - multi-cycle SD2 remainder conversion and quotient/remainder rounding correction
// Converts DPC signed digits per cycle LSB first, then applies the +/-div fix-up in a single cycle.
module intdiv_adj_seq #(
  parameter int WIDTH = 8,
  parameter int DPC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               xmsb_i,
  input  logic               ymsb_i,
  input  logic [WIDTH-1:0]   div_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [2*WIDTH-1:0] rem_sd_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   quo_out_o,
  output logic [WIDTH-1:0]   rem_out_o,
  output logic               padj_o,
  output logic               seladj_o
);

  localparam int NCYC  = (WIDTH + DPC - 1) / DPC;
  localparam int CW    = NCYC * DPC;
  localparam int KW    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int LASTN = WIDTH - (NCYC - 1) * DPC;
  localparam logic [KW-1:0] KLAST = KW'(NCYC - 1);

  localparam logic [1:0] SD_NEG1 = 2'b00;
  localparam logic [1:0] SD_POS1 = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIX, S_DONE} state_t;

  state_t               state_q;
  logic [KW-1:0]        k_q;
  logic [2*WIDTH-1:0]   sd_q;
  logic [CW-1:0]        conv_q;
  logic [CW-1:0]        conv_d;
  logic                 borrow_q;
  logic                 zero_q;
  logic                 zero_d;
  logic                 mode_q;
  logic                 xmsb_q;
  logic                 ymsb_q;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     quo_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     quo_out_q;
  logic [WIDTH-1:0]     rem_out_q;
  logic                 padj_q;
  logic                 seladj_q;

  logic [DPC:0]         bchain;
  logic [DPC-1:0]       cbits;
  logic [DPC-1:0]       cvalid;

  // Per-slot borrow chain: bit = pos - neg - borrow, so bit is the parity and borrow
  // propagates whenever the difference goes negative.
  assign bchain[0] = borrow_q;
  for (genvar j = 0; j < DPC; j++) begin : g_slot
    logic p;
    logic n;
    assign p             = (sd_q[2*j+1:2*j] == SD_POS1);
    assign n             = (sd_q[2*j+1:2*j] == SD_NEG1);
    assign cbits[j]      = p ^ n ^ bchain[j];
    assign bchain[j+1]   = n | (~p & bchain[j]);
    if (j < LASTN) begin : g_full
      assign cvalid[j] = 1'b1;
    end else begin : g_tail
      assign cvalid[j] = (k_q != KLAST);
    end
  end

  if (NCYC > 1) begin : g_shift
    assign conv_d = {cbits, conv_q[CW-1:DPC]};
  end else begin : g_single
    assign conv_d = cbits;
  end

  assign zero_d = zero_q & ~|(cbits & cvalid);

  logic [WIDTH-1:0] r;
  logic             rs;
  logic             tsign;
  logic             adj;
  logic             toward_div;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  always_comb begin
    r          = conv_q[WIDTH-1:0];
    rs         = r[WIDTH-1];
    tsign      = mode_q ? xmsb_q : ymsb_q;
    adj        = ~zero_q & (rs != tsign);
    toward_div = (rs == xmsb_q);
    rem_fix    = toward_div ? (r - div_q) : (r + div_q);
    quo_fix    = toward_div ? (quo_q + WIDTH'(1)) : (quo_q - WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      sd_q      <= '0;
      conv_q    <= '0;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b1;
      mode_q    <= 1'b0;
      xmsb_q    <= 1'b0;
      ymsb_q    <= 1'b0;
      div_q     <= '0;
      quo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      padj_q    <= 1'b0;
      seladj_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q   <= mode_i;
            xmsb_q   <= xmsb_i;
            ymsb_q   <= ymsb_i;
            div_q    <= div_i;
            quo_q    <= quo_i;
            sd_q     <= rem_sd_i;
            conv_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          sd_q     <= sd_q >> (2 * DPC);
          conv_q   <= conv_d;
          borrow_q <= bchain[DPC];
          zero_q   <= zero_d;
          if (k_q == KLAST) begin
            state_q <= S_FIX;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_FIX: begin
          if (adj) begin
            rem_out_q <= rem_fix;
            quo_out_q <= quo_fix;
            padj_q    <= 1'b1;
            seladj_q  <= 1'b0;
          end else begin
            rem_out_q <= r;
            quo_out_q <= quo_q;
            padj_q    <= 1'b0;
            seladj_q  <= 1'b1;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign quo_out_o = quo_out_q;
  assign rem_out_o = rem_out_q;
  assign padj_o    = padj_q;
  assign seladj_o  = seladj_q;

endmodule

// File: tb/tb_intdiv_adj_seq.sv
// tb/tb_intdiv_adj_seq.sv - self-checking bench for intdiv_adj_seq at DPC 2, 3 and 8
// Three instances share one stimulus stream and are checked against an integer-sum reference model.
module tb_intdiv_adj_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic        xmsb;
  logic        ymsb;
  logic [7:0]  div;
  logic [7:0]  quo;
  logic [15:0] rem_sd;

  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [2:0]  padj_w;
  logic [2:0]  seladj_w;
  logic [7:0]  quo_w [3];
  logic [7:0]  rem_w [3];

  int n_checks = 0;
  int n_fail   = 0;
  int dpcs[3]  = '{2, 3, 8};
  int lat[3]   = '{6, 5, 3};

  always #5 clk = ~clk;

  intdiv_adj_seq #(.WIDTH(8), .DPC(2)) u_dpc2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .xmsb_i(xmsb), .ymsb_i(ymsb),
    .div_i(div), .quo_i(quo), .rem_sd_i(rem_sd), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .quo_out_o(quo_w[0]), .rem_out_o(rem_w[0]), .padj_o(padj_w[0]), .seladj_o(seladj_w[0])
  );
  intdiv_adj_seq #(.WIDTH(8), .DPC(3)) u_dpc3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .xmsb_i(xmsb), .ymsb_i(ymsb),
    .div_i(div), .quo_i(quo), .rem_sd_i(rem_sd), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .quo_out_o(quo_w[1]), .rem_out_o(rem_w[1]), .padj_o(padj_w[1]), .seladj_o(seladj_w[1])
  );
  intdiv_adj_seq #(.WIDTH(8), .DPC(8)) u_dpc8 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .xmsb_i(xmsb), .ymsb_i(ymsb),
    .div_i(div), .quo_i(quo), .rem_sd_i(rem_sd), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .quo_out_o(quo_w[2]), .rem_out_o(rem_w[2]), .padj_o(padj_w[2]), .seladj_o(seladj_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Remainder value is the plain weighted digit sum; digit codes 00=-1, 01/10=0, 11=+1.
  task automatic model(input logic m, input logic xm, input logic ym, input logic [7:0] dv,
                       input logic [7:0] q, input logic [15:0] rs,
                       output logic [7:0] eq, output logic [7:0] er,
                       output logic ep, output logic es);
    int rv;
    int code;
    logic [7:0] r8;
    logic t;
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      code = int'(rs >> (2 * i)) & 3;
      if (code == 3) rv += (1 << i);
      else if (code == 0) rv -= (1 << i);
    end
    r8 = rv[7:0];
    t  = m ? xm : ym;
    if (r8 != 8'd0 && r8[7] != t) begin
      ep = 1'b1;
      es = 1'b0;
      if (r8[7] == xm) begin
        er = r8 - dv;
        eq = q + 8'd1;
      end else begin
        er = r8 + dv;
        eq = q - 8'd1;
      end
    end else begin
      ep = 1'b0;
      es = 1'b1;
      er = r8;
      eq = q;
    end
  endtask

  task automatic run_op(input string name, input logic m, input logic xm, input logic ym,
                        input logic [7:0] dv, input logic [7:0] q, input logic [15:0] rs,
                        input bit reissue);
    logic [7:0] eq;
    logic [7:0] er;
    logic ep;
    logic es;
    int ndone[3];
    int dcyc[3];
    model(m, xm, ym, dv, q, rs, eq, er, ep, es);
    @(negedge clk);
    mode = m; xmsb = xm; ymsb = ym; div = dv; quo = q; rem_sd = rs; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/dpc%0d/busy_after_accept", name, dpcs[d]), 32'(busy_w[d]), 32'd1);
      ndone[d] = 0;
      dcyc[d]  = -1;
    end
    for (int c = 1; c <= 10; c++) begin
      if (reissue && c == 1) begin
        start  = 1'b1;
        mode   = ~m;
        div    = 8'($urandom);
        quo    = 8'($urandom);
        rem_sd = 16'($urandom);
        xmsb   = ~xm;
        ymsb   = ~ym;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (done_w[d]) begin
          ndone[d]++;
          dcyc[d] = c;
          check($sformatf("%s/dpc%0d/busy_at_done", name, dpcs[d]), 32'(busy_w[d]), 32'd0);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/dpc%0d/done_count", name, dpcs[d]), 32'(ndone[d]), 32'd1);
      check($sformatf("%s/dpc%0d/latency", name, dpcs[d]), 32'(dcyc[d]), 32'(lat[d]));
      check($sformatf("%s/dpc%0d/quo_out", name, dpcs[d]), 32'(quo_w[d]), 32'(eq));
      check($sformatf("%s/dpc%0d/rem_out", name, dpcs[d]), 32'(rem_w[d]), 32'(er));
      check($sformatf("%s/dpc%0d/padj", name, dpcs[d]), 32'(padj_w[d]), 32'(ep));
      check($sformatf("%s/dpc%0d/seladj", name, dpcs[d]), 32'(seladj_w[d]), 32'(es));
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/dpc%0d/busy", name, dpcs[d]), 32'(busy_w[d]), 32'd0);
      check($sformatf("%s/dpc%0d/done", name, dpcs[d]), 32'(done_w[d]), 32'd0);
      check($sformatf("%s/dpc%0d/quo_out", name, dpcs[d]), 32'(quo_w[d]), 32'd0);
      check($sformatf("%s/dpc%0d/rem_out", name, dpcs[d]), 32'(rem_w[d]), 32'd0);
      check($sformatf("%s/dpc%0d/padj", name, dpcs[d]), 32'(padj_w[d]), 32'd0);
      check($sformatf("%s/dpc%0d/seladj", name, dpcs[d]), 32'(seladj_w[d]), 32'd1);
    end
  endtask

  initial begin
    int ndone;
    logic m;
    logic [7:0] dv;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; xmsb = 1'b0; ymsb = 1'b0;
    div = '0; quo = '0; rem_sd = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_trunc", 1'b0, 1'b0, 1'b1, 8'd2, 8'hFC, 16'h5557, 1'b0);
    run_op("t2_floor", 1'b1, 1'b0, 1'b1, 8'd2, 8'hFC, 16'h5557, 1'b0);
    run_op("t3_floor", 1'b1, 1'b1, 1'b0, 8'hF8, 8'hFE, 16'h55D4, 1'b0);
    run_op("t3_trunc", 1'b0, 1'b1, 1'b0, 8'hF8, 8'hFE, 16'h55D4, 1'b0);
    run_op("t4_zero", 1'b0, 1'b0, 1'b1, 8'd3, 8'd5, 16'h6666, 1'b0);
    run_op("t5_reissue", 1'b0, 1'b0, 1'b1, 8'd2, 8'hFC, 16'h5557, 1'b1);

    for (int i = 0; i < 24; i++) begin
      m  = 1'($urandom);
      dv = 8'($urandom);
      run_op($sformatf("rnd%0d", i), m, dv[7], 1'($urandom), dv, 8'($urandom),
             16'($urandom), (i % 4) == 0);
    end

    // Abort mid-conversion: all instances are in their first conversion cycle here.
    @(negedge clk);
    mode = 1'b0; xmsb = 1'b1; ymsb = 1'b0; div = 8'hF8; quo = 8'hFE; rem_sd = 16'h55D4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done_w != 3'b000) ndone++;
    end
    check("abort/no_done", 32'(ndone), 32'd0);
    check_reset_state("abort_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
